// File: rtl/fft_butterfly_r2.sv
// Pipelined radix-2 DIT butterfly: X = A + W*B, Y = A - W*B on complex fixed-point samples.
// Three register stages behind a single global stall; final add/sub runs on 32-bit CLAs.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;

    assign g = a & b;
    assign p = a ^ b;

    // 4-bit lookahead groups; group carries chain through group generate/propagate
    always_comb begin
        c     = '0;
        gg    = '0;
        gp    = '0;
        c[0]  = cin;
        for (int j = 0; j < 8; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
            c[4*j+1] = g[4*j] | (p[4*j] & c[4*j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & c[4*j]);
            c[4*j+4] = gg[j] | (gp[j] & c[4*j]);
        end
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];
endmodule

module fft_butterfly_r2 #(
    parameter int DW = 16,
    parameter int TW = 16,
    parameter int OW = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_re,
    input  logic signed [TW-1:0] w_im,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] x_re,
    output logic signed [OW-1:0] x_im,
    output logic signed [OW-1:0] y_re,
    output logic signed [OW-1:0] y_im,
    output logic                 out_last,
    output logic [15:0]          bfly_cnt
);
    localparam int PW = DW + TW;
    localparam int RW = DW + 2;
    localparam logic signed [PW:0] RND = (PW+1)'(1) << (TW - 2);

    function automatic logic signed [RW-1:0] round_half_up(input logic signed [PW:0] v);
        logic signed [PW:0] t;
        t = v + RND;
        return t[PW:TW-1];
    endfunction

    function automatic logic signed [31:0] sext_a(input logic signed [DW-1:0] v);
        return 32'(v);
    endfunction

    function automatic logic signed [31:0] sext_p(input logic signed [RW-1:0] v);
        return 32'(v);
    endfunction

    logic en;
    logic vld_p1, last_p1, vld_p2, last_p2;
    logic signed [DW-1:0] a_re_p1, a_im_p1, b_re_p1, b_im_p1;
    logic signed [TW-1:0] w_re_p1, w_im_p1;
    logic signed [PW-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
    logic signed [PW:0]   p_re, p_im;
    logic signed [31:0]   a_re_p2, a_im_p2, pr_re_p2, pr_im_p2;
    logic [31:0] x_re_sum, x_im_sum, y_re_sum, y_im_sum;
    logic        x_re_co, x_im_co, y_re_co, y_im_co;
    logic        unused_bits;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            last_p1   <= 1'b0;
            vld_p2    <= 1'b0;
            last_p2   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            vld_p1    <= in_valid;
            last_p1   <= in_valid & in_last;
            vld_p2    <= vld_p1;
            last_p2   <= last_p1;
            out_valid <= vld_p2;
            out_last  <= last_p2;
        end
    end

    // Stage 1: capture operands
    always_ff @(posedge clk) begin
        if (en) begin
            a_re_p1 <= a_re;
            a_im_p1 <= a_im;
            b_re_p1 <= b_re;
            b_im_p1 <= b_im;
            w_re_p1 <= w_re;
            w_im_p1 <= w_im;
        end
    end

    assign prod_rr = PW'(b_re_p1) * PW'(w_re_p1);
    assign prod_ii = PW'(b_im_p1) * PW'(w_im_p1);
    assign prod_ri = PW'(b_re_p1) * PW'(w_im_p1);
    assign prod_ir = PW'(b_im_p1) * PW'(w_re_p1);
    assign p_re    = (PW+1)'(prod_rr) - (PW+1)'(prod_ii);
    assign p_im    = (PW+1)'(prod_ri) + (PW+1)'(prod_ir);

    // Stage 2: rounded W*B and A, widened to the adder width
    always_ff @(posedge clk) begin
        if (en) begin
            a_re_p2  <= sext_a(a_re_p1);
            a_im_p2  <= sext_a(a_im_p1);
            pr_re_p2 <= sext_p(round_half_up(p_re));
            pr_im_p2 <= sext_p(round_half_up(p_im));
        end
    end

    cla32 u_x_re (.a(a_re_p2), .b(pr_re_p2),  .cin(1'b0), .sum(x_re_sum), .cout(x_re_co));
    cla32 u_x_im (.a(a_im_p2), .b(pr_im_p2),  .cin(1'b0), .sum(x_im_sum), .cout(x_im_co));
    cla32 u_y_re (.a(a_re_p2), .b(~pr_re_p2), .cin(1'b1), .sum(y_re_sum), .cout(y_re_co));
    cla32 u_y_im (.a(a_im_p2), .b(~pr_im_p2), .cin(1'b1), .sum(y_im_sum), .cout(y_im_co));

    // Results fit in OW bits, so carries and upper sum bits carry no information
    assign unused_bits = ^{x_re_co, x_im_co, y_re_co, y_im_co,
                           x_re_sum[31:OW], x_im_sum[31:OW], y_re_sum[31:OW], y_im_sum[31:OW]};

    // Stage 3: output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_re <= '0;
            x_im <= '0;
            y_re <= '0;
            y_im <= '0;
        end else if (en) begin
            x_re <= x_re_sum[OW-1:0];
            x_im <= x_im_sum[OW-1:0];
            y_re <= y_re_sum[OW-1:0];
            y_im <= y_im_sum[OW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bfly_cnt <= '0;
        end else if (out_valid && out_ready) begin
            bfly_cnt <= out_last ? 16'd0 : bfly_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Directed bench for fft_butterfly_r2 with a scoreboard fed at input transfers
// and drained at output transfers.

module tb_fft_butterfly_r2;
    logic clk = 1'b0;
    logic rst_n, in_valid, in_last, out_ready;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic in_ready, out_valid, out_last;
    logic signed [17:0] x_re, x_im, y_re, y_im;
    logic [15:0] bfly_cnt;

    typedef struct {
        longint xr, xi, yr, yi;
        bit     last;
    } exp_t;

    exp_t sb[$];
    exp_t hold;
    int   checks = 0;
    int   errors = 0;
    int   mcnt = 0;
    bit   mon_on = 0;
    bit   prev_stall = 0;

    always #5 clk = ~clk;

    fft_butterfly_r2 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
        .out_last(out_last), .bfly_cnt(bfly_cnt)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint ar, ai, br, bi, wr, wi, input bit last);
        exp_t e;
        longint pre, pim, rr, ri;
        pre = br * wr - bi * wi;
        pim = br * wi + bi * wr;
        rr  = (pre + 16384) >>> 15;
        ri  = (pim + 16384) >>> 15;
        e.xr = ar + rr;
        e.xi = ai + ri;
        e.yr = ar - rr;
        e.yi = ai - ri;
        e.last = last;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mon_on) begin
            if (!rst_n) begin
                sb.delete();
                mcnt = 0;
                prev_stall = 0;
            end else begin
                chk("in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
                if (prev_stall) begin
                    chk("hold_x_re", x_re, hold.xr);
                    chk("hold_x_im", x_im, hold.xi);
                    chk("hold_y_re", y_re, hold.yr);
                    chk("hold_y_im", y_im, hold.yi);
                    chk("hold_last", out_last, hold.last);
                end
                if (in_valid && in_ready)
                    sb.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, in_last));
                if (out_valid && out_ready) begin
                    checks++;
                    assert (sb.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_out: observed x_re=%0d with empty scoreboard expected no output", x_re);
                    end
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("x_re", x_re, e.xr);
                        chk("x_im", x_im, e.xi);
                        chk("y_re", y_re, e.yr);
                        chk("y_im", y_im, e.yi);
                        chk("out_last", out_last, e.last);
                        chk("bfly_cnt", bfly_cnt, mcnt);
                        mcnt = e.last ? 0 : (mcnt + 1) % 65536;
                    end
                end
                prev_stall = out_valid && !out_ready;
                hold.xr = x_re;
                hold.xi = x_im;
                hold.yr = y_re;
                hold.yi = y_im;
                hold.last = out_last;
            end
        end
    end

    task automatic drive_beat(input int ar, ai, br, bi, wr, wi, input bit last);
        bit done;
        done = 0;
        a_re = 16'(ar); a_im = 16'(ai);
        b_re = 16'(br); b_im = 16'(bi);
        w_re = 16'(wr); w_im = 16'(wi);
        in_last  = last;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: observed in_ready=0 for 50 cycles expected acceptance");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    initial begin
        int lat;
        bit [3:0] pat;
        pat = 4'b1001;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_bfly_cnt", bfly_cnt, 0);
        chk("rst_x_re", x_re, 0);
        chk("rst_y_im", y_im, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // real twiddle, with latency measurement
        drive_beat(100, 0, 200, 0, 32767, 0, 0);
        in_valid = 1'b0;
        lat = 1;
        for (int c = 0; c < 10 && !out_valid; c++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 3);
        chk("lat_x_re", x_re, 300);
        chk("lat_y_re", y_re, -100);
        idle(4);

        drive_beat(0, 0, 10, 20, 0, -32768, 0);
        idle(5);
        drive_beat(-32768, -32768, -32768, -32768, -32768, -32768, 0);
        idle(5);

        // backpressure: 8 streamed beats against a 1,0,0,1 ready pattern
        fork
            begin
                for (int i = 0; i < 8; i++)
                    drive_beat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0);
                in_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    out_ready = pat[i % 4];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        idle(6);
        chk("bp_drained", sb.size(), 0);

        // reset with three beats in flight
        for (int i = 0; i < 3; i++)
            drive_beat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), 0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_bfly_cnt", bfly_cnt, 0);
        chk("midrst_x_re", x_re, 0);
        rst_n = 1'b1;
        idle(6);

        // last/count: counter reads 0,1,2,3 then clears
        for (int i = 0; i < 4; i++)
            drive_beat(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), i == 3);
        idle(6);
        chk("cnt_after_last", bfly_cnt, 0);
        chk("out_last_idle", out_last, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
